// File: rtl/gpu_vram_burst_responder.sv
// gpu_vram_burst_responder
//   Memory-side executor for the GPU segment command stream. Queues RDBURST/WRBURST
//   commands, runs 8-beat x 32-bit bursts on the VRAM port, and keeps read data in a
//   2-bank x 8-word segment buffer that a later WRBURST writes back under a pixel mask.
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_cmdValid/o_cmdAccept       command handshake (accept = FIFO not full)
//   i_cmd/i_cmdAdr/i_cmdBank/i_cmdMask  command code, segment index, buffer bank, pixel mask
//   o_memReq/i_memAck            burst request handshake, o_memWrite/o_memAdr describe it
//   i_memRValid/i_memRData       read beats
//   i_memWReady/o_memWData/o_memBE  write beats
//   o_busy                       FIFO non-empty or burst engine active
//   o_rdDone                     one-cycle pulse after the last read beat is stored
module gpu_vram_burst_responder #(
  parameter int unsigned CMD_DEPTH       = 4,
  parameter logic [2:0]  MEM_CMD_RDBURST = 3'd1,
  parameter logic [2:0]  MEM_CMD_WRBURST = 3'd2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmdValid,
  output logic        o_cmdAccept,
  input  logic [2:0]  i_cmd,
  input  logic [14:0] i_cmdAdr,
  input  logic        i_cmdBank,
  input  logic [15:0] i_cmdMask,
  output logic        o_memReq,
  input  logic        i_memAck,
  output logic        o_memWrite,
  output logic [14:0] o_memAdr,
  input  logic        i_memRValid,
  input  logic [31:0] i_memRData,
  input  logic        i_memWReady,
  output logic [31:0] o_memWData,
  output logic [3:0]  o_memBE,
  output logic        o_busy,
  output logic        o_rdDone
);

  localparam int unsigned PTR_W  = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned ADR_W  = 15;
  localparam int unsigned MASK_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BEAT_W = 3;
  localparam int unsigned NBEAT  = 8;

  typedef struct packed {
    logic [2:0]        cmd;
    logic [ADR_W-1:0]  adr;
    logic              bank;
    logic [MASK_W-1:0] mask;
  } cmd_t;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RDATA, ST_WDATA} state_t;

  // Byte enables of one beat: two 16-bit pixels, low pixel in the low half.
  function automatic logic [3:0] beat_be(input logic [MASK_W-1:0] mask,
                                         input logic [BEAT_W-1:0] beat);
    logic [1:0] px;
    px = mask[{beat, 1'b0} +: 2];
    return {px[1], px[1], px[0], px[0]};
  endfunction

  cmd_t              fifo_q [CMD_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              full, empty, push, pop, head_runs;
  cmd_t              in_cmd, head;

  state_t            state_q;
  logic [BEAT_W-1:0] beat_q, beat_nxt;
  logic [ADR_W-1:0]  adr_q;
  logic              bank_q;
  logic [MASK_W-1:0] mask_q;
  logic              mem_write_q;
  logic              req_q, rd_done_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        be_q;

  logic [DATA_W-1:0] seg_q [2][NBEAT];

  // FIFO flags come from the registered count only.
  assign full      = (cnt_q == CNT_W'(CMD_DEPTH));
  assign empty     = (cnt_q == '0);
  assign push      = i_cmdValid && !full;
  assign pop       = (state_q == ST_IDLE) && !empty;
  assign in_cmd    = '{cmd: i_cmd, adr: i_cmdAdr, bank: i_cmdBank, mask: i_cmdMask};
  assign head      = fifo_q[rd_ptr_q];
  // Only real bursts with something to do leave IDLE; the rest are dropped at pop.
  assign head_runs = (head.cmd == MEM_CMD_RDBURST) ||
                     ((head.cmd == MEM_CMD_WRBURST) && (head.mask != '0));
  assign beat_nxt  = beat_q + BEAT_W'(1);

  // Command FIFO storage.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= in_cmd;
    end
  end

  // Command FIFO pointers and occupancy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Segment buffer: filled by read beats, never cleared.
  always_ff @(posedge i_clk) begin
    if (!i_rst && (state_q == ST_RDATA) && i_memRValid) begin
      seg_q[bank_q][beat_q] <= i_memRData;
    end
  end

  // Burst engine.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      adr_q       <= '0;
      bank_q      <= 1'b0;
      mask_q      <= '0;
      mem_write_q <= 1'b0;
      req_q       <= 1'b0;
      rd_done_q   <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
    end else begin
      rd_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            adr_q       <= head.adr;
            bank_q      <= head.bank;
            mask_q      <= head.mask;
            mem_write_q <= (head.cmd == MEM_CMD_WRBURST);
            if (head_runs) begin
              state_q <= ST_REQ;
              req_q   <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (i_memAck) begin
            req_q  <= 1'b0;
            beat_q <= '0;
            if (mem_write_q) begin
              state_q <= ST_WDATA;
              wdata_q <= seg_q[bank_q][BEAT_W'(0)];
              be_q    <= beat_be(mask_q, BEAT_W'(0));
            end else begin
              state_q <= ST_RDATA;
            end
          end
        end
        ST_RDATA: begin
          if (i_memRValid) begin
            beat_q <= beat_nxt;
            if (beat_q == BEAT_W'(NBEAT - 1)) begin
              state_q   <= ST_IDLE;
              rd_done_q <= 1'b1;
            end
          end
        end
        ST_WDATA: begin
          // Data/BE of the next beat are loaded on the edge that consumes the current one.
          if (i_memWReady) begin
            beat_q <= beat_nxt;
            if (beat_q == BEAT_W'(NBEAT - 1)) begin
              state_q <= ST_IDLE;
              wdata_q <= '0;
              be_q    <= '0;
            end else begin
              wdata_q <= seg_q[bank_q][beat_nxt];
              be_q    <= beat_be(mask_q, beat_nxt);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_cmdAccept = !full;
  assign o_memReq    = req_q;
  assign o_memWrite  = mem_write_q;
  assign o_memAdr    = adr_q;
  assign o_memWData  = wdata_q;
  assign o_memBE     = be_q;
  assign o_rdDone    = rd_done_q;
  assign o_busy      = !empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_gpu_vram_burst_responder.sv
// tb_gpu_vram_burst_responder
//   Directed bench for gpu_vram_burst_responder: reset, read burst, read/write-back,
//   masked writes, FIFO full/order, reset mid-burst and write back-pressure.
module tb_gpu_vram_burst_responder;

  localparam logic [2:0] RD  = 3'd1;
  localparam logic [2:0] WR  = 3'd2;
  localparam logic [2:0] NOP = 3'd5;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_cmdValid = 1'b0;
  logic        o_cmdAccept;
  logic [2:0]  i_cmd = 3'd0;
  logic [14:0] i_cmdAdr = 15'd0;
  logic        i_cmdBank = 1'b0;
  logic [15:0] i_cmdMask = 16'd0;
  logic        o_memReq;
  logic        i_memAck = 1'b0;
  logic        o_memWrite;
  logic [14:0] o_memAdr;
  logic        i_memRValid = 1'b0;
  logic [31:0] i_memRData = 32'd0;
  logic        i_memWReady = 1'b0;
  logic [31:0] o_memWData;
  logic [3:0]  o_memBE;
  logic        o_busy;
  logic        o_rdDone;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_t5 [8];

  gpu_vram_burst_responder dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmdValid(i_cmdValid), .o_cmdAccept(o_cmdAccept), .i_cmd(i_cmd),
    .i_cmdAdr(i_cmdAdr), .i_cmdBank(i_cmdBank), .i_cmdMask(i_cmdMask),
    .o_memReq(o_memReq), .i_memAck(i_memAck), .o_memWrite(o_memWrite), .o_memAdr(o_memAdr),
    .i_memRValid(i_memRValid), .i_memRData(i_memRData),
    .i_memWReady(i_memWReady), .o_memWData(o_memWData), .o_memBE(o_memBE),
    .o_busy(o_busy), .o_rdDone(o_rdDone)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic push(input logic [2:0] c, input logic [14:0] a, input logic b, input logic [15:0] m);
    for (int n = 0; n < 50 && !o_cmdAccept; n++) tick();
    i_cmdValid = 1'b1; i_cmd = c; i_cmdAdr = a; i_cmdBank = b; i_cmdMask = m;
    tick();
    i_cmdValid = 1'b0;
  endtask

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (o_memReq) begin got = 1'b1; break; end
      tick();
    end
  endtask

  task automatic ack;
    i_memAck = 1'b1;
    tick();
    i_memAck = 1'b0;
  endtask

  task automatic test_reset;
    i_rst = 1'b1; tick(); tick(); i_rst = 1'b0;
    checks++; if (o_cmdAccept !== 1'b1) begin failures++; $display("FAIL reset_accept got=%0h exp=1", o_cmdAccept); end
    checks++; if (o_memReq !== 1'b0) begin failures++; $display("FAIL reset_req got=%0h exp=0", o_memReq); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", o_busy); end
    checks++; if (o_rdDone !== 1'b0) begin failures++; $display("FAIL reset_rddone got=%0h exp=0", o_rdDone); end
    checks++; if (o_memWrite !== 1'b0) begin failures++; $display("FAIL reset_write got=%0h exp=0", o_memWrite); end
    checks++; if (o_memAdr !== 15'd0) begin failures++; $display("FAIL reset_adr got=%0h exp=0", o_memAdr); end
    checks++; if (o_memWData !== 32'd0) begin failures++; $display("FAIL reset_wdata got=%0h exp=0", o_memWData); end
    checks++; if (o_memBE !== 4'd0) begin failures++; $display("FAIL reset_be got=%0h exp=0", o_memBE); end
  endtask

  task automatic test_read_burst;
    logic [31:0] d;
    i_cmdValid = 1'b1; i_cmd = RD; i_cmdAdr = 15'h1234; i_cmdBank = 1'b0; i_cmdMask = 16'h0;
    tick();
    i_cmdValid = 1'b0;
    checks++; if (o_memReq !== 1'b0) begin failures++; $display("FAIL t1_req_early got=%0h exp=0", o_memReq); end
    checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL t1_busy_queued got=%0h exp=1", o_busy); end
    tick();
    checks++; if (o_memReq !== 1'b1) begin failures++; $display("FAIL t1_req_latency got=%0h exp=1", o_memReq); end
    checks++; if (o_memAdr !== 15'h1234) begin failures++; $display("FAIL t1_adr got=%0h exp=1234", o_memAdr); end
    checks++; if (o_memWrite !== 1'b0) begin failures++; $display("FAIL t1_write got=%0h exp=0", o_memWrite); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (o_memReq !== 1'b1 || o_memAdr !== 15'h1234) begin failures++; $display("FAIL t1_req_hold k=%0d req=%0h adr=%0h exp req=1 adr=1234", k, o_memReq, o_memAdr); end
    end
    ack();
    checks++; if (o_memReq !== 1'b0) begin failures++; $display("FAIL t1_req_after_ack got=%0h exp=0", o_memReq); end
    for (int i = 0; i < 8; i++) begin
      d = 32'h1111_1111 * (i + 1);
      i_memRValid = 1'b1; i_memRData = d;
      tick();
      i_memRValid = 1'b0;
      checks++; if (o_rdDone !== (i == 7)) begin failures++; $display("FAIL t1_rddone beat=%0d got=%0h exp=%0h", i, o_rdDone, (i == 7)); end
      if (i == 3) begin
        tick();
        checks++; if (o_rdDone !== 1'b0) begin failures++; $display("FAIL t1_rddone_gap got=%0h exp=0", o_rdDone); end
      end
    end
    tick();
    checks++; if (o_rdDone !== 1'b0) begin failures++; $display("FAIL t1_rddone_pulse got=%0h exp=0", o_rdDone); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL t1_busy_end got=%0h exp=0", o_busy); end
  endtask

  task automatic test_read_writeback;
    bit got;
    logic [31:0] d [8];
    push(RD, 15'h0200, 1'b1, 16'h0);
    push(WR, 15'h0010, 1'b1, 16'hFFFF);
    wait_req(got);
    checks++; if (!got || o_memAdr !== 15'h0200 || o_memWrite !== 1'b0) begin failures++; $display("FAIL t2_rd_req got=%0d adr=%0h wr=%0h exp adr=200 wr=0", got, o_memAdr, o_memWrite); end
    ack();
    for (int i = 0; i < 8; i++) begin
      d[i] = 32'hA500_0000 + (i * 32'h0001_0203);
      i_memRValid = 1'b1; i_memRData = d[i];
      tick();
    end
    i_memRValid = 1'b0;
    wait_req(got);
    checks++; if (!got || o_memAdr !== 15'h0010 || o_memWrite !== 1'b1) begin failures++; $display("FAIL t2_wr_req got=%0d adr=%0h wr=%0h exp adr=10 wr=1", got, o_memAdr, o_memWrite); end
    ack();
    for (int i = 0; i < 8; i++) begin
      checks++; if (o_memWData !== d[i] || o_memBE !== 4'hF) begin failures++; $display("FAIL t2_wbeat beat=%0d data=%0h be=%0h exp data=%0h be=f", i, o_memWData, o_memBE, d[i]); end
      i_memWReady = 1'b1;
      tick();
    end
    i_memWReady = 1'b0;
    checks++; if (o_memWData !== 32'd0 || o_memBE !== 4'd0 || o_busy !== 1'b0) begin failures++; $display("FAIL t2_end data=%0h be=%0h busy=%0h exp 0 0 0", o_memWData, o_memBE, o_busy); end
  endtask

  task automatic test_masked_write;
    bit got;
    logic [31:0] d;
    push(WR, 15'h0100, 1'b0, 16'h0003);
    wait_req(got);
    checks++; if (!got || o_memWrite !== 1'b1) begin failures++; $display("FAIL t3_req got=%0d wr=%0h exp 1 1", got, o_memWrite); end
    ack();
    for (int i = 0; i < 8; i++) begin
      d = 32'h1111_1111 * (i + 1);
      checks++; if (o_memBE !== ((i == 0) ? 4'hF : 4'h0) || o_memWData !== d) begin failures++; $display("FAIL t3_wbeat beat=%0d be=%0h data=%0h exp be=%0h data=%0h", i, o_memBE, o_memWData, (i == 0) ? 4'hF : 4'h0, d); end
      i_memWReady = 1'b1;
      tick();
    end
    i_memWReady = 1'b0;
    checks++; if (o_memBE !== 4'd0 || o_busy !== 1'b0) begin failures++; $display("FAIL t3_end be=%0h busy=%0h exp 0 0", o_memBE, o_busy); end
    push(WR, 15'h0300, 1'b0, 16'h0000);
    checks++; if (o_busy !== 1'b1 || o_memReq !== 1'b0) begin failures++; $display("FAIL t3_mask0_queued busy=%0h req=%0h exp 1 0", o_busy, o_memReq); end
    tick();
    checks++; if (o_busy !== 1'b0 || o_memReq !== 1'b0) begin failures++; $display("FAIL t3_mask0_drop busy=%0h req=%0h exp 0 0", o_busy, o_memReq); end
    tick();
    checks++; if (o_memReq !== 1'b0) begin failures++; $display("FAIL t3_mask0_noreq got=%0h exp=0", o_memReq); end
    push(NOP, 15'h07FF, 1'b0, 16'hFFFF);
    tick();
    checks++; if (o_busy !== 1'b0 || o_memReq !== 1'b0) begin failures++; $display("FAIL t3_nop_drop busy=%0h req=%0h exp 0 0", o_busy, o_memReq); end
  endtask

  task automatic test_fifo_full_order;
    bit got;
    logic [14:0] a [6];
    for (int k = 0; k < 6; k++) a[k] = 15'h00A0 + 15'(k);
    for (int k = 0; k < 5; k++) begin
      checks++; if (o_cmdAccept !== 1'b1) begin failures++; $display("FAIL t4_accept k=%0d got=%0h exp=1", k, o_cmdAccept); end
      i_cmdValid = 1'b1; i_cmd = RD; i_cmdAdr = a[k]; i_cmdBank = 1'b0; i_cmdMask = 16'h0;
      tick();
    end
    i_cmdAdr = a[5];
    for (int k = 0; k < 3; k++) begin
      checks++; if (o_cmdAccept !== 1'b0) begin failures++; $display("FAIL t4_refuse k=%0d got=%0h exp=0", k, o_cmdAccept); end
      tick();
    end
    i_cmdValid = 1'b0;
    i_memRValid = 1'b1; i_memRData = 32'hDEAD_0000;
    for (int k = 0; k < 6; k++) begin
      wait_req(got);
      checks++; if (!got || o_memAdr !== a[k]) begin failures++; $display("FAIL t4_order k=%0d got=%0d adr=%0h exp=%0h", k, got, o_memAdr, a[k]); end
      if (k == 1) begin
        checks++; if (o_cmdAccept !== 1'b1) begin failures++; $display("FAIL t4_accept_after_pop got=%0h exp=1", o_cmdAccept); end
        push(RD, a[5], 1'b0, 16'h0);
      end
      ack();
    end
    for (int n = 0; n < 20 && o_busy; n++) tick();
    i_memRValid = 1'b0;
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL t4_drain busy=%0h exp=0", o_busy); end
  endtask

  task automatic test_reset_mid_read;
    bit got;
    push(RD, 15'h0777, 1'b1, 16'h0);
    wait_req(got);
    ack();
    for (int i = 0; i < 3; i++) begin
      i_memRValid = 1'b1; i_memRData = 32'hBAD0_0000 + 32'(i);
      tick();
    end
    i_memRValid = 1'b0;
    checks++; if (!got || o_busy !== 1'b1) begin failures++; $display("FAIL t5_busy_pre got=%0d busy=%0h exp 1 1", got, o_busy); end
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    checks++; if (o_memReq !== 1'b0 || o_busy !== 1'b0 || o_cmdAccept !== 1'b1 || o_rdDone !== 1'b0) begin failures++; $display("FAIL t5_after_rst req=%0h busy=%0h acc=%0h done=%0h exp 0 0 1 0", o_memReq, o_busy, o_cmdAccept, o_rdDone); end
    for (int i = 0; i < 5; i++) begin
      i_memRValid = 1'b1; i_memRData = 32'hBADB_AD00 + 32'(i);
      tick();
      checks++; if (o_rdDone !== 1'b0 || o_busy !== 1'b0) begin failures++; $display("FAIL t5_late_beat i=%0d done=%0h busy=%0h exp 0 0", i, o_rdDone, o_busy); end
    end
    i_memRValid = 1'b0;
    push(RD, 15'h0055, 1'b1, 16'h0);
    wait_req(got);
    checks++; if (!got || o_memAdr !== 15'h0055 || o_memWrite !== 1'b0) begin failures++; $display("FAIL t5_new_req got=%0d adr=%0h wr=%0h exp adr=55 wr=0", got, o_memAdr, o_memWrite); end
    ack();
    for (int i = 0; i < 8; i++) begin
      exp_t5[i] = 32'hC0DE_0000 + (i * 32'h0000_1111);
      i_memRValid = 1'b1; i_memRData = exp_t5[i];
      tick();
      checks++; if (o_rdDone !== (i == 7)) begin failures++; $display("FAIL t5_rddone beat=%0d got=%0h exp=%0h", i, o_rdDone, (i == 7)); end
    end
    i_memRValid = 1'b0;
    tick();
  endtask

  task automatic test_write_backpressure;
    bit got;
    bit rdy;
    int n;
    logic [3:0] ebe [8];
    ebe = '{4'hF, 4'h0, 4'h3, 4'hC, 4'h0, 4'hF, 4'hC, 4'h3};
    push(WR, 15'h0066, 1'b1, 16'h6C93);
    wait_req(got);
    checks++; if (!got || o_memWrite !== 1'b1 || o_memAdr !== 15'h0066) begin failures++; $display("FAIL t6_req got=%0d wr=%0h adr=%0h exp wr=1 adr=66", got, o_memWrite, o_memAdr); end
    ack();
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 8; cyc++) begin
      checks++; if (o_memWData !== exp_t5[n] || o_memBE !== ebe[n]) begin failures++; $display("FAIL t6_wbeat beat=%0d cyc=%0d data=%0h be=%0h exp data=%0h be=%0h", n, cyc, o_memWData, o_memBE, exp_t5[n], ebe[n]); end
      rdy = ((cyc % 2) == 0);
      i_memWReady = rdy;
      tick();
      if (rdy) n++;
    end
    i_memWReady = 1'b0;
    checks++; if (o_memWData !== 32'd0 || o_memBE !== 4'd0 || o_busy !== 1'b0) begin failures++; $display("FAIL t6_end data=%0h be=%0h busy=%0h exp 0 0 0", o_memWData, o_memBE, o_busy); end
    i_memWReady = 1'b1;
    tick(); tick();
    i_memWReady = 1'b0;
    checks++; if (o_memBE !== 4'd0 || o_memReq !== 1'b0) begin failures++; $display("FAIL t6_no_extra be=%0h req=%0h exp 0 0", o_memBE, o_memReq); end
  endtask

  initial begin
    test_reset();
    test_read_burst();
    test_read_writeback();
    test_masked_write();
    test_fifo_full_order();
    test_reset_mid_read();
    test_write_backpressure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
